// File: rtl/gate_unit_arbiter_pkg.sv
// Shared widths and helpers for the gate unit arbiter.
package gate_unit_arbiter_pkg;

  localparam int unsigned OP_W = 3;
  localparam int unsigned ID_W = 3;

`include "gate_arb_defs.vh"

  // Round-robin successor of idx among n requesters.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] idx, input int unsigned n);
    logic [31:0] nxt;
    nxt = 32'(idx) + 32'd1;
    return (nxt >= n) ? '0 : ID_W'(nxt);
  endfunction

endpackage

// File: rtl/gate_alu.sv
// Shared combinational bitwise gate unit built from gate primitives.
module gate_alu
  import gate_unit_arbiter_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic [W-1:0]    y
);

  logic [W-1:0] and_y, or_y, xor_y, nand_y, nor_y, xnor_y, not_a;

  for (genvar i = 0; i < W; i++) begin : g_bit
    and u_and  (and_y[i], a[i], b[i]);
    or  u_or   (or_y[i], a[i], b[i]);
    xor u_xor  (xor_y[i], a[i], b[i]);
    not u_nand (nand_y[i], and_y[i]);
    not u_nor  (nor_y[i], or_y[i]);
    not u_xnor (xnor_y[i], xor_y[i]);
    not u_nota (not_a[i], a[i]);
  end

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = and_y;
      OP_OR:   y = or_y;
      OP_XOR:  y = xor_y;
      OP_NAND: y = nand_y;
      OP_NOR:  y = nor_y;
      OP_XNOR: y = xnor_y;
      OP_NOT:  y = not_a;
      OP_BUF:  y = a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/gate_arb_defs.vh
// Shared opcode and FSM state encodings for the gate unit arbiter.
localparam logic [2:0] OP_AND  = 3'd0;
localparam logic [2:0] OP_OR   = 3'd1;
localparam logic [2:0] OP_XOR  = 3'd2;
localparam logic [2:0] OP_NAND = 3'd3;
localparam logic [2:0] OP_NOR  = 3'd4;
localparam logic [2:0] OP_XNOR = 3'd5;
localparam logic [2:0] OP_NOT  = 3'd6;
localparam logic [2:0] OP_BUF  = 3'd7;
localparam logic [0:0] S_IDLE = 1'b0;
localparam logic [0:0] S_HOLD = 1'b1;

// File: rtl/gate_unit_arbiter.sv
// Round-robin arbiter sharing one gate unit among NREQ requesters, 1-deep output register.
// Optional per-requester saturating grant counters under GATE_ARB_STATS_EN.
module gate_unit_arbiter
  import gate_unit_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [OP_W*NREQ-1:0] req_op,
  input  logic [W*NREQ-1:0]    req_a,
  input  logic [W*NREQ-1:0]    req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [W-1:0]         rsp_data,
  output logic [ID_W-1:0]      rsp_id
`ifdef GATE_ARB_STATS_EN
  ,
  output logic [16*NREQ-1:0]   stat_grants
`endif
);

  logic [0:0]      state, state_nxt;
  logic [ID_W-1:0] ptr;
  logic            can_grant, grant;
  logic            hi_any, lo_any, gnt_any;
  logic [ID_W-1:0] hi_idx, lo_idx, gnt_idx;
  logic [OP_W-1:0] sel_op;
  logic [W-1:0]    sel_a, sel_b, alu_y;

  assign can_grant = (state == S_IDLE) || rsp_ready;
  assign grant     = can_grant && gnt_any;
  assign rsp_valid = (state == S_HOLD);

  // Round-robin: first pending index at or above ptr, else first one below ptr.
  always_comb begin : rr_search
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_valid[i] && (ID_W'(i) >= ptr) && !hi_any) begin
        hi_any = 1'b1;
        hi_idx = ID_W'(i);
      end
      if (req_valid[i] && (ID_W'(i) < ptr) && !lo_any) begin
        lo_any = 1'b1;
        lo_idx = ID_W'(i);
      end
    end
    gnt_any = hi_any || lo_any;
    gnt_idx = hi_any ? hi_idx : lo_idx;
  end

  always_comb begin : operand_mux
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_op = req_op[i*OP_W +: OP_W];
        sel_a  = req_a[i*W +: W];
        sel_b  = req_b[i*W +: W];
      end
    end
  end

  // Acceptance is same-cycle, so req_ready is decoded combinationally from the grant.
  always_comb begin : ready_decode
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (rst_n && grant && (gnt_idx == ID_W'(i))) req_ready[i] = 1'b1;
    end
  end

  gate_alu #(.W(W)) u_alu (
    .op (sel_op),
    .a  (sel_a),
    .b  (sel_b),
    .y  (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin : fsm_next
    state_nxt = state;
    case (state)
      S_IDLE:  if (gnt_any) state_nxt = S_HOLD;
      S_HOLD:  if (rsp_ready && !gnt_any) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_id   <= '0;
      ptr      <= '0;
    end else if (grant) begin
      rsp_data <= alu_y;
      rsp_id   <= gnt_idx;
      ptr      <= wrap_inc(gnt_idx, NREQ);
    end
  end

`ifdef GATE_ARB_STATS_EN
  localparam int unsigned CNT_W = 16;
  logic [CNT_W-1:0] cnt [NREQ];

  // Saturating per-requester grant counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant && (gnt_idx == ID_W'(i)) && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int unsigned i = 0; i < NREQ; i++) stat_grants[i*CNT_W +: CNT_W] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// Self-checking bench for gate_unit_arbiter: vector table, directed corner sequences, random vs model.
module tb_gate_unit_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [3*NREQ-1:0]    req_op;
  logic [W*NREQ-1:0]    req_a;
  logic [W*NREQ-1:0]    req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [W-1:0]         rsp_data;
  logic [2:0]           rsp_id;
`ifdef GATE_ARB_STATS_EN
  logic [16*NREQ-1:0]   stat_grants;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: held result and rotation pointer.
  bit           m_held;
  logic [W-1:0] m_data;
  int           m_id;
  int           m_ptr;

  typedef struct {
    int           idx;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;
  vec_t tbl [10];

  gate_unit_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_id      (rsp_id)
`ifdef GATE_ARB_STATS_EN
    ,
    .stat_grants (stat_grants)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] gate_ref(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_held = 1'b0;
    m_data = '0;
    m_id   = 0;
    m_ptr  = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock with current inputs: predict, compare mid-cycle, then advance the model.
  task automatic cycle_check(input string tag);
    int g;
    logic [NREQ-1:0] er;
    g = -1;
    if (!m_held || rsp_ready) begin
      for (int k = 0; k < int'(NREQ); k++) begin
        int j;
        j = (m_ptr + k) % int'(NREQ);
        if (g < 0 && req_valid[j]) g = j;
      end
    end
    er = (g >= 0) ? NREQ'(1 << g) : '0;
    @(negedge clk);
    chk({tag, " req_ready"}, 32'(req_ready), 32'(er));
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(m_held));
    if (m_held) begin
      chk({tag, " rsp_data"}, 32'(rsp_data), 32'(m_data));
      chk({tag, " rsp_id"}, 32'(rsp_id), 32'(m_id));
    end
    @(posedge clk);
    if (g >= 0) begin
      m_held = 1'b1;
      m_data = gate_ref(req_op[g*3 +: 3], req_a[g*W +: W], req_b[g*W +: W]);
      m_id   = g;
      m_ptr  = (g + 1) % int'(NREQ);
    end else if (m_held && rsp_ready) begin
      m_held = 1'b0;
    end
    #1;
  endtask

  task automatic randomize_operands();
    req_op = 12'($urandom);
    req_a  = $urandom;
    req_b  = $urandom;
  endtask

  initial begin
    req_valid = '1;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    model_reset();

    tbl[0] = '{0, 3'd0, 8'hF0, 8'h3C, 8'h30};
    tbl[1] = '{1, 3'd1, 8'hF0, 8'h3C, 8'hFC};
    tbl[2] = '{2, 3'd2, 8'hF0, 8'h3C, 8'hCC};
    tbl[3] = '{3, 3'd3, 8'hF0, 8'h3C, 8'hCF};
    tbl[4] = '{0, 3'd4, 8'hF0, 8'h3C, 8'h03};
    tbl[5] = '{1, 3'd5, 8'hF0, 8'h3C, 8'h33};
    tbl[6] = '{2, 3'd6, 8'h5A, 8'($urandom), 8'hA5};
    tbl[7] = '{3, 3'd7, 8'hF0, 8'h3C, 8'hF0};
    tbl[8] = '{0, 3'd3, 8'hFF, 8'hFF, 8'h00};
    tbl[9] = '{1, 3'd6, 8'hF0, 8'h3C, 8'h0F};

    // Outputs held at reset values while rst_n is low, even with requests pending.
    #12;
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_data", 32'(rsp_data), 32'd0);
    chk("reset rsp_id", 32'(rsp_id), 32'd0);
    chk("reset req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Single request, AND, one-cycle latency.
    req_valid = 4'b0001;
    req_op    = '0;
    req_a     = {24'($urandom), 8'hF0};
    req_b     = {24'($urandom), 8'h3C};
    rsp_ready = 1'b1;
    cycle_check("s031");
    chk("s031 rsp_valid", 32'(rsp_valid), 32'd1);
    chk("s031 rsp_data", 32'(rsp_data), 32'h30);
    chk("s031 rsp_id", 32'(rsp_id), 32'd0);
    req_valid = '0;
    cycle_check("s031 drain");

    // Opcode table; non-granted lanes carry random junk.
    for (int t = 0; t < 10; t++) begin
      randomize_operands();
      req_valid = NREQ'(1) << tbl[t].idx;
      req_op[tbl[t].idx*3 +: 3] = tbl[t].op;
      req_a[tbl[t].idx*W +: W]  = tbl[t].a;
      req_b[tbl[t].idx*W +: W]  = tbl[t].b;
      rsp_ready = 1'b1;
      cycle_check("tbl");
      chk($sformatf("tbl%0d rsp_data", t), 32'(rsp_data), 32'(tbl[t].exp));
      chk($sformatf("tbl%0d rsp_id", t), 32'(rsp_id), 32'(tbl[t].idx));
    end
    req_valid = '0;
    cycle_check("tbl drain");

    // All requesting, consumer always ready: 0,1,2,3,0 back to back.
    do_reset();
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      randomize_operands();
      cycle_check("s032");
      chk($sformatf("s032 rsp_valid %0d", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("s032 rsp_id %0d", k), 32'(rsp_id), 32'(k % 4));
    end

    // Back-pressure for 5 cycles: result frozen, no acceptance, then grant resumes at 1.
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      randomize_operands();
      cycle_check("s033 stall");
      chk($sformatf("s033 rsp_id %0d", k), 32'(rsp_id), 32'd0);
    end
    rsp_ready = 1'b1;
    cycle_check("s033 release");
    chk("s033 next grant", 32'(rsp_id), 32'd1);

    // Asynchronous reset mid-HOLD drops the result at once and rewinds the pointer.
    #2;
    rst_n = 1'b0;
    #1;
    chk("s035 async rsp_valid", 32'(rsp_valid), 32'd0);
    chk("s035 async rsp_data", 32'(rsp_data), 32'd0);
    chk("s035 async req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    randomize_operands();
    cycle_check("s035");
    chk("s035 first grant", 32'(rsp_id), 32'd1);

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      randomize_operands();
      req_valid = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      cycle_check("rand");
    end

`ifdef GATE_ARB_STATS_EN
    // Saturation of requester 2's counter.
    req_valid = '0;
    do_reset();
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    req_valid = '0;
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(NREQ); i++) begin
      chk($sformatf("stat_grants[%0d]", i), 32'(stat_grants[i*16 +: 16]), (i == 2) ? 32'h0000FFFF : 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
